// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-like slave backed by a word memory, with fixed-latency in-order responses
module sram_like_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    logic [31:0]           mem    [2**ADDR_WIDTH];
    logic [31:0]           q_data [OUTSTANDING];
    logic [AGE_W-1:0]      q_age  [OUTSTANDING];
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      wptr;
    logic                  ready;
    logic                  accept;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            be;
    logic                  unused_addr;

    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    function automatic logic [AGE_W-1:0] next_age(input logic [AGE_W-1:0] a);
        return (a == AGE_W'(LATENCY)) ? a : a + 1'b1;
    endfunction

    // Accept/retire decisions; accept ignores a same-cycle retire so a full queue never accepts
    always_comb begin
        idx     = addr[ADDR_WIDTH+1:2];
        addr_ok = req && rst && ready && (count < CNT_W'(OUTSTANDING));
        accept  = addr_ok;
        pop     = rst && (count != '0) && (q_age[0] == AGE_W'(LATENCY));
        data_ok = pop;
        rdata   = pop ? q_data[0] : '0;
        wptr    = count - CNT_W'(pop);
        be      = (size == 2'b00) ? 4'b0001 << addr[1:0] :
                  (size == 2'b01 && !addr[0]) ? (addr[1] ? 4'b1100 : 4'b0011) :
                  (size == 2'b10 && addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
    end

    // Byte-enabled memory write; illegal or misaligned requests produce an empty mask
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // In-order shift queue: head at slot 0, new entry lands behind the surviving entries
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            ready <= 1'b0;
            for (int i = 0; i < OUTSTANDING; i++) q_age[i] <= '0;
        end else begin
            ready <= 1'b1;
            for (int i = 0; i < OUTSTANDING; i++) q_age[i] <= next_age(q_age[i]);
            if (pop) begin
                for (int i = 0; i < OUTSTANDING - 1; i++) begin
                    q_data[i] <= q_data[i+1];
                    q_age[i]  <= next_age(q_age[i+1]);
                end
            end
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (accept && wptr == CNT_W'(i)) begin
                    q_data[i] <= wr ? '0 : mem[idx];
                    q_age[i]  <= AGE_W'(1);
                end
            end
            count <= count + CNT_W'(accept) - CNT_W'(pop);
        end
    end
endmodule
